// File: rtl/iteration_controller.sv
// iteration_controller: sequences one iterative-solver run (seed, sample handshake, stability/timeout decision).
// Define ITER_CTRL_ABORT_EN to add the i_abort port that forces an early timeout.
module iteration_controller #(
  parameter int DATA_W     = 8,
  parameter int ITER_W     = 8,
  parameter int STABLE_CNT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_seed_val,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_sample_valid,
  input  logic [DATA_W-1:0] i_sample_val,
  output logic              o_sample_ready,
  output logic [DATA_W-1:0] o_old_val,
  output logic [DATA_W-1:0] o_new_val,
  input  logic              i_conv_flag,
`ifdef ITER_CTRL_ABORT_EN
  input  logic              i_abort,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_converged,
  output logic              o_timeout,
  output logic [ITER_W-1:0] o_iter_count,
  output logic [DATA_W-1:0] o_result_val
);
  localparam int SW = $clog2(STABLE_CNT + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;
  state_t            r_state, w_state;
  logic [DATA_W-1:0] r_old, w_old, r_new, w_new;
  logic [ITER_W-1:0] r_max, w_max, r_iter, w_iter;
  logic [SW-1:0]     r_stable, w_stable, w_stable_inc;
  logic              r_conv, w_conv, r_tmo, w_tmo;
  logic              w_busy, w_abort, w_start, w_accept, w_hit;
  assign w_busy = (r_state == S_WAIT) || (r_state == S_CHECK);
`ifdef ITER_CTRL_ABORT_EN
  assign w_abort = i_abort && w_busy;
`else
  assign w_abort = 1'b0;
`endif
  assign w_start      = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_accept     = (r_state == S_WAIT) && i_sample_valid && !w_abort;
  assign w_stable_inc = r_stable + 1'b1;
  assign w_hit        = i_conv_flag && (w_stable_inc == SW'(STABLE_CNT));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_old    <= '0;
      r_new    <= '0;
      r_max    <= '0;
      r_iter   <= '0;
      r_stable <= '0;
      r_conv   <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_old    <= w_old;
      r_new    <= w_new;
      r_max    <= w_max;
      r_iter   <= w_iter;
      r_stable <= w_stable;
      r_conv   <= w_conv;
      r_tmo    <= w_tmo;
    end
  end
  always_comb begin
    w_state  = r_state;
    w_old    = r_old;
    w_new    = r_new;
    w_max    = r_max;
    w_iter   = r_iter;
    w_stable = r_stable;
    w_conv   = r_conv;
    w_tmo    = r_tmo;
    if (w_start) begin
      w_old    = i_seed_val;
      w_new    = i_seed_val;
      w_max    = i_max_iter;
      w_iter   = '0;
      w_stable = '0;
      w_conv   = 1'b0;
      w_tmo    = (i_max_iter == '0);
      w_state  = (i_max_iter == '0) ? S_DONE : S_WAIT;
    end else if (w_abort) begin
      w_state = S_DONE;
      w_conv  = 1'b0;
      w_tmo   = 1'b1;
    end else if (w_accept) begin
      w_new   = i_sample_val;
      w_iter  = r_iter + 1'b1;
      w_state = S_CHECK;
    end else if (r_state == S_CHECK) begin
      w_old    = r_new;
      w_stable = i_conv_flag ? w_stable_inc : '0;
      // convergence wins a tie with budget exhaustion
      w_conv   = w_hit;
      w_tmo    = !w_hit && (r_iter == r_max);
      w_state  = (w_hit || (r_iter == r_max)) ? S_DONE : S_WAIT;
    end
  end
  assign o_sample_ready = (r_state == S_WAIT) && !w_abort;
  assign o_old_val      = r_old;
  assign o_new_val      = r_new;
  assign o_busy         = w_busy;
  assign o_done         = (r_state == S_DONE);
  assign o_converged    = r_conv;
  assign o_timeout      = r_tmo;
  assign o_iter_count   = r_iter;
  assign o_result_val   = r_new;
endmodule

// File: tb/tb_iteration_controller.sv
// tb_iteration_controller: scoreboard bench; a |old-new|<=1 tolerance checker feeds conv_flag.
module tb_iteration_controller;
  typedef struct {
    logic       conv;
    logic       tmo;
    logic [7:0] iter;
    logic [7:0] res;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed_val = '0;
  logic [7:0] max_iter = '0;
  logic       valid = 1'b0;
  logic [7:0] sval = '0;
  logic       abort = 1'b0;
  logic       ready, busy, done, conv_o, tmo_o, conv_flag;
  logic [7:0] old_v, new_v, iter, res;
  logic [7:0] smp [8];
  exp_t       q[$];
  int         n_chk = 0;
  int         n_pass = 0;
  always #5 clk = ~clk;
  assign conv_flag = ((old_v > new_v) ? 8'(old_v - new_v) : 8'(new_v - old_v)) <= 8'd1;
  iteration_controller dut (
    .clk(clk), .rst_n(rst_n), .i_start(start), .i_seed_val(seed_val), .i_max_iter(max_iter),
    .i_sample_valid(valid), .i_sample_val(sval), .o_sample_ready(ready),
    .o_old_val(old_v), .o_new_val(new_v), .i_conv_flag(conv_flag),
`ifdef ITER_CTRL_ABORT_EN
    .i_abort(abort),
`endif
    .o_busy(busy), .o_done(done), .o_converged(conv_o), .o_timeout(tmo_o),
    .o_iter_count(iter), .o_result_val(res)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic wait_done();
    int w = 0;
    exp_t e;
    while (!done && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", done, 1);
    e = q.pop_front();
    check("converged", conv_o, e.conv);
    check("timeout", tmo_o, e.tmo);
    check("iter_count", iter, e.iter);
    check("result_val", res, e.res);
    check("busy_off", busy, 0);
  endtask
  task automatic run(input logic [7:0] seed, input logic [7:0] mx, input int n, input bit poke, input exp_t e);
    q.push_back(e);
    @(negedge clk);
    start = 1'b1;
    seed_val = seed;
    max_iter = mx;
    @(negedge clk);
    start = 1'b0;
    check("done_lat", done, mx == 0);
    check("busy_on", busy, mx != 0);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (!ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w == 20) check("ready_wait", ready, 1);
      valid = 1'b1;
      sval = smp[i];
      if (poke && i == 1) begin
        start = 1'b1;
        seed_val = 8'd99;
        max_iter = 8'd0;
      end
      @(negedge clk);
      valid = 1'b0;
      start = 1'b0;
    end
    wait_done();
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_iter", iter, 0);
    check("rst_res", res, 0);
    rst_n = 1'b1;
    smp = '{8'd20, 8'd21, 8'd21, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run(8'd10, 8'd8, 3, 1'b0, '{1'b1, 1'b0, 8'd3, 8'd21});
    smp = '{8'd11, 8'd30, 8'd31, 8'd31, 8'd0, 8'd0, 8'd0, 8'd0};
    run(8'd10, 8'd8, 4, 1'b1, '{1'b1, 1'b0, 8'd4, 8'd31});
    smp = '{8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run(8'd0, 8'd3, 3, 1'b0, '{1'b0, 1'b1, 8'd3, 8'd30});
    smp = '{8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run(8'd5, 8'd2, 2, 1'b0, '{1'b1, 1'b0, 8'd2, 8'd5});
    run(8'd42, 8'd0, 0, 1'b0, '{1'b0, 1'b1, 8'd0, 8'd42});
    // sample_valid held high: ready must alternate, one acceptance per WAIT
    q.push_back('{1'b0, 1'b1, 8'd4, 8'd70});
    @(negedge clk);
    start = 1'b1;
    seed_val = 8'd0;
    max_iter = 8'd4;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sval = 8'(10 * k);
      check("ready_toggle", ready, (k % 2) == 1);
      @(negedge clk);
    end
    valid = 1'b0;
    wait_done();
    // reset asserted in WAIT with a pending sample
    @(negedge clk);
    start = 1'b1;
    seed_val = 8'd7;
    max_iter = 8'd5;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    sval = 8'd9;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_old", old_v, 0);
    check("mid_rst_new", new_v, 0);
    check("mid_rst_iter", iter, 0);
    check("mid_rst_flags", {done, conv_o, tmo_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {busy, done}, 0);
    check("post_rst_iter", iter, 0);
`ifdef ITER_CTRL_ABORT_EN
    q.push_back('{1'b0, 1'b1, 8'd2, 8'd11});
    start = 1'b1;
    seed_val = 8'd10;
    max_iter = 8'd8;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b1;
    sval = 8'd11;
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
